// File: rtl/down_counter_pkg.sv
// Shared types and default widths for the down-counter and its up-counter sibling.
// The state encoding is fixed; the unused code 2'b11 is treated as IDLE.
package down_counter_pkg;

  localparam int COUNT_W_DEF = 4;
  localparam int WRAP_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  function automatic state_t decode_state(input logic [1:0] raw);
    case (raw)
      2'b01:   return RUN;
      2'b10:   return EXPIRED;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/down_counter_if.sv
// Control and status bundle between a down-counter and whatever drives it.
// master drives the strobes; slave is the counter itself.
interface down_counter_if #(
  parameter int WIDTH  = down_counter_pkg::COUNT_W_DEF,
  parameter int WRAP_W = down_counter_pkg::WRAP_W_DEF
);
  logic              enable;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              reload_en;
  logic [WIDTH-1:0]  count;
  logic              zero;
  logic              tc_pulse;
  logic              running;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output enable, load, load_value, reload_en,
    input  count, zero, tc_pulse, running, wrap_cnt
  );

  modport slave (
    input  enable, load, load_value, reload_en,
    output count, zero, tc_pulse, running, wrap_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: clr wins over inc, sticks at all-ones, one-cycle update.
// No backpressure; inc is simply ignored once saturated.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter with one-shot or auto-reload terminal count; all outputs registered.
// Load beats enable; the count is held in any cycle without enable, nothing is ever dropped.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH  = COUNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t            state_q, state_d, cur_state;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic              tc_q, tc_d;
  logic              zero_q, run_q;
  logic              wrap_inc;
  logic [WRAP_W-1:0] wrap_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      zero_q   <= 1'b1;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      zero_q   <= (count_d == '0);
      run_q    <= (state_d == RUN);
    end
  end

  always_comb begin
    cur_state = decode_state(state_q);
    state_d   = cur_state;
    count_d   = count_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    wrap_inc  = 1'b0;

    if (bus.load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      state_d  = (bus.load_value != '0) ? RUN : IDLE;
    end else if ((cur_state == RUN) && bus.enable) begin
      // RUN always holds count>=1, so the <= guard only makes the decrement wrap-proof.
      if (count_q <= ONE) begin
        tc_d = 1'b1;
        if (bus.reload_en) begin
          count_d  = reload_q;
          wrap_inc = 1'b1;
        end else begin
          count_d = '0;
          state_d = EXPIRED;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.load),
    .inc   (wrap_inc),
    .value (wrap_value)
  );

  assign bus.count    = count_q;
  assign bus.zero     = zero_q;
  assign bus.tc_pulse = tc_q;
  assign bus.running  = run_q;
  assign bus.wrap_cnt = wrap_value;

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_down_counter;

  localparam int W  = 4;
  localparam int WW = 8;
  localparam int WRAP_MAX = (1 << WW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(W), .WRAP_W(WW)) dif ();

  down_counter #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  typedef struct {
    logic [W-1:0]  count;
    logic          zero;
    logic          tc;
    logic          run;
    logic [WW-1:0] wrap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: remaining ticks, reload period, mode (0 idle, 1 counting, 2 expired).
  int m_count, m_reload, m_mode, m_wrap, m_tc;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_mode = 0; m_wrap = 0; m_tc = 0;
  endtask

  task automatic step(input bit en, input bit ld, input int lv, input bit re);
    exp_t e;
    @(negedge clk);
    dif.enable     = en;
    dif.load       = ld;
    dif.load_value = lv[W-1:0];
    dif.reload_en  = re;
    m_tc = 0;
    if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_wrap   = 0;
      m_mode   = (lv != 0) ? 1 : 0;
    end else if (m_mode == 1 && en) begin
      if (m_count == 1) begin
        m_tc = 1;
        if (re) begin
          m_count = m_reload;
          m_wrap  = (m_wrap < WRAP_MAX) ? m_wrap + 1 : WRAP_MAX;
        end else begin
          m_count = 0;
          m_mode  = 2;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
    e.count = m_count[W-1:0];
    e.zero  = (m_count == 0);
    e.tc    = m_tc[0];
    e.run   = (m_mode == 1);
    e.wrap  = m_wrap[WW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("count",    int'(dif.count),    int'(e.count));
        check("zero",     int'(dif.zero),     int'(e.zero));
        check("tc_pulse", int'(dif.tc_pulse), int'(e.tc));
        check("running",  int'(dif.running),  int'(e.run));
        check("wrap_cnt", int'(dif.wrap_cnt), int'(e.wrap));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    bit re_r;
    reset          = 1'b0;
    dif.enable     = 1'b0;
    dif.load       = 1'b0;
    dif.load_value = '0;
    dif.reload_en  = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    check("rst_count",   int'(dif.count),    0);
    check("rst_zero",    int'(dif.zero),     1);
    check("rst_running", int'(dif.running),  0);
    check("rst_tc",      int'(dif.tc_pulse), 0);
    check("rst_wrap",    int'(dif.wrap_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with enable high: nothing moves.
    repeat (5) step(1, 0, 0, 0);

    // One-shot from 5, then ten more enabled cycles parked at zero.
    step(1, 1, 5, 0);
    repeat (15) step(1, 0, 0, 0);
    settle();
    check("oneshot_count",   int'(dif.count),   0);
    check("oneshot_running", int'(dif.running), 0);

    // Auto-reload period 3 for 12 enabled cycles.
    step(1, 1, 3, 1);
    repeat (12) step(1, 0, 0, 1);
    settle();
    check("reload_wrap",  int'(dif.wrap_cnt), 4);
    check("reload_count", int'(dif.count),    3);

    // Gated enable pattern.
    step(0, 1, 4, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    settle();
    check("gated_count", int'(dif.count),    0);
    check("gated_tc",    int'(dif.tc_pulse), 1);

    // Load beats the terminal cycle.
    step(0, 1, 2, 1);
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(1, 1, 9, 1);
    settle();
    check("prio_count", int'(dif.count),    9);
    check("prio_tc",    int'(dif.tc_pulse), 0);
    check("prio_wrap",  int'(dif.wrap_cnt), 0);

    step(1, 1, 0, 0);
    settle();
    check("load0_running", int'(dif.running),  0);
    check("load0_zero",    int'(dif.zero),     1);

    // Full-scale one-shot.
    step(0, 1, 15, 0);
    repeat (15) step(1, 0, 0, 0);
    settle();
    check("full_tc",      int'(dif.tc_pulse), 1);
    check("full_running", int'(dif.running),  0);

    // Period-1 reload long enough to saturate the wrap counter.
    step(0, 1, 1, 1);
    repeat (WRAP_MAX + 20) step(1, 0, 0, 1);
    settle();
    check("sat_wrap",  int'(dif.wrap_cnt), WRAP_MAX);
    check("sat_count", int'(dif.count),    1);

    // Asynchronous reset between edges.
    step(0, 1, 15, 1);
    repeat (6) step(1, 0, 0, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_count",   int'(dif.count),    0);
    check("arst_running", int'(dif.running),  0);
    check("arst_zero",    int'(dif.zero),     1);
    check("arst_tc",      int'(dif.tc_pulse), 0);
    check("arst_wrap",    int'(dif.wrap_cnt), 0);
    model_reset();
    dif.load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic.
    re_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) re_r = ~re_r;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 15)), re_r);
    end

    settle();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
